// File: rtl/zle_pkg.sv
// Shared zero run-length token definitions for the ZLE encoder and the zld_xca decoder.
// Token layout: bit TOK_RUN_BIT selects literal (value in low W bits) or zero run (low W bits = length-1).
package zle_pkg;

  localparam int W           = 3;
  localparam int TW          = W + 1;
  localparam int TOK_RUN_BIT = W;

  localparam logic TOK_LIT = 1'b0;
  localparam logic TOK_RUN = 1'b1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/zld_xca_if.sv
// Token-in / value-out stream bundle for zld_xca; each side is data, valid and back-pressure.
// slave is the decoder's view, master is the surrounding producer/consumer.
interface zld_xca_if;
  import zle_pkg::*;

  logic [TW-1:0] i_d;
  logic          i_v;
  logic          i_b;
  logic [W-1:0]  o_d;
  logic          o_v;
  logic          o_b;

  modport slave  (input  i_d, i_v, o_b, output i_b, o_d, o_v);
  modport master (output i_d, i_v, o_b, input  i_b, o_d, o_v);

endinterface

// File: rtl/zld_xca_fsm.sv
// Control for the zero run-length decoder: state register, token acceptance,
// back-pressure and load enables for the datapath registers.
//
//   state | meaning
//   LOAD  | accepting tokens; literals and single-zero runs never leave LOAD
//   RUN   | emitting the remaining zeros of a run, no tokens accepted
module zld_xca_fsm
  import zle_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_v,
  input  logic o_v,
  input  logic o_b,
  input  logic cnt_one,
  input  logic tok_run,
  input  logic run_zero,
  output logic i_b,
  output logic accept,
  output logic od_load,
  output logic od_lit,
  output logic ov_load,
  output logic ov_next,
  output logic cnt_load,
  output logic cnt_dec
);

  state_e state_q;
  state_e state_d;
  logic   slot_free;
  logic   in_run;

  assign slot_free = ~(o_v & o_b);
  assign in_run    = (state_q == RUN);

  // Stall upstream while reset is held, too, so nothing is lost across reset.
  assign i_b = ~reset | in_run | ~slot_free;

  always_comb begin
    accept   = ~in_run & slot_free & i_v;
    od_lit   = accept & ~tok_run;
    od_load  = slot_free & (accept | in_run);
    ov_load  = slot_free;
    ov_next  = in_run | i_v;
    cnt_load = accept & tok_run;
    cnt_dec  = slot_free & in_run;
    state_d  = state_q;
    if (accept && tok_run && !run_zero) begin
      state_d = RUN;
    end
    if (in_run && slot_free && cnt_one) begin
      state_d = LOAD;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/zld_xca.sv
// Zero run-length decoder top: turns ZLE tokens back into the W-bit value stream.
// Optional ZLD_ERRCHK_EN adds a sticky err output flagging literal-zero tokens.
module zld_xca
  import zle_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  zld_xca_if.slave    bus
`ifdef ZLD_ERRCHK_EN
  ,
  output logic        err
`endif
);

  logic [W-1:0] o_d_q;
  logic         o_v_q;
  logic [W-1:0] cnt_q;

  logic [TW-1:0] tok;
  logic          tok_run;
  logic          run_zero;
  logic          cnt_one;
  logic          accept;
  logic          od_load;
  logic          od_lit;
  logic          ov_load;
  logic          ov_next;
  logic          cnt_load;
  logic          cnt_dec;

  assign tok      = bus.i_d;
  assign tok_run  = (tok[TOK_RUN_BIT] == TOK_RUN);
  assign run_zero = (tok[W-1:0] == '0);
  assign cnt_one  = (cnt_q == W'(1));

  zld_xca_fsm u_fsm (
    .clock    (clock),
    .reset    (reset),
    .i_v      (bus.i_v),
    .o_v      (o_v_q),
    .o_b      (bus.o_b),
    .cnt_one  (cnt_one),
    .tok_run  (tok_run),
    .run_zero (run_zero),
    .i_b      (bus.i_b),
    .accept   (accept),
    .od_load  (od_load),
    .od_lit   (od_lit),
    .ov_load  (ov_load),
    .ov_next  (ov_next),
    .cnt_load (cnt_load),
    .cnt_dec  (cnt_dec)
  );

  // cnt counts zeros still owed after the one emitted on acceptance; RUN exits at 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_d_q <= '0;
      o_v_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (od_load) begin
        o_d_q <= od_lit ? tok[W-1:0] : '0;
      end
      if (ov_load) begin
        o_v_q <= ov_next;
      end
      if (cnt_load) begin
        cnt_q <= tok[W-1:0];
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign bus.o_d = o_d_q;
  assign bus.o_v = o_v_q;

`ifdef ZLD_ERRCHK_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept && !tok_run && run_zero) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_zld_xca.sv
// Directed bench for zld_xca: literal stream, runs, run boundaries, back-pressure,
// reset mid-run, literal-zero token and (with ZLD_ERRCHK_EN) the sticky err flag.
module tb_zld_xca;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  zld_xca_if bus ();

`ifdef ZLD_ERRCHK_EN
  logic err;
  zld_xca dut (.clock(clock), .reset(reset), .bus(bus), .err(err));
`else
  zld_xca dut (.clock(clock), .reset(reset), .bus(bus));
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check i_b before the edge, then the registered outputs after it.
  task automatic cyc(input string tag, input logic [3:0] tok, input logic v, input logic ob,
                     input logic eib, input logic eov, input logic [2:0] eod);
    bus.i_d = tok;
    bus.i_v = v;
    bus.o_b = ob;
    #1;
    chk({tag, " i_b"}, 32'(bus.i_b), 32'(eib));
    @(posedge clock);
    #1;
    chk({tag, " o_v"}, 32'(bus.o_v), 32'(eov));
    if (eov) chk({tag, " o_d"}, 32'(bus.o_d), 32'(eod));
  endtask

  task automatic idle(input string tag);
    cyc(tag, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bus.i_d  = '0;
    bus.i_v  = 1'b0;
    bus.o_b  = 1'b0;

    #2;
    chk("rst i_b", 32'(bus.i_b), 32'd1);
    chk("rst o_v", 32'(bus.o_v), 32'd0);
    chk("rst o_d", 32'(bus.o_d), 32'd0);
`ifdef ZLD_ERRCHK_EN
    chk("rst err", 32'(err), 32'd0);
`endif
    #10 reset = 1'b1;
    @(posedge clock);
    #1;

    cyc("lit5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    cyc("lit3", 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    cyc("lit7", 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
    idle("lit idle");

    cyc("runA z1", 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    cyc("runA z2", 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    cyc("runA z3", 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    cyc("runA lit1", 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    idle("runA idle");

    cyc("runF z1", 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 2; i <= 8; i++) begin
      cyc($sformatf("runF z%0d", i), 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    end
    idle("runF idle");

    cyc("run8 z1", 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    cyc("run8 lit6", 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
    idle("run8 idle");

    cyc("bp z1", 4'hB, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    cyc("bp z2", 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("bp hold%0d", i), 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    end
    cyc("bp z3", 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    cyc("bp z4", 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    cyc("bp lit4", 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    cyc("bp lhold", 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    cyc("bp lit5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    idle("bp idle");

    cyc("mr z1", 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    cyc("mr z2", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    bus.i_d = 4'h2;
    bus.i_v = 1'b1;
    reset   = 1'b0;
    #1;
    chk("mr rst o_v", 32'(bus.o_v), 32'd0);
    chk("mr rst i_b", 32'(bus.i_b), 32'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    cyc("mr lit2", 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    idle("mr idle");

    cyc("lz z", 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
`ifdef ZLD_ERRCHK_EN
    chk("err set", 32'(err), 32'd1);
`endif
    cyc("lz lit5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    cyc("lz run8", 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    idle("lz idle");
`ifdef ZLD_ERRCHK_EN
    chk("err sticky", 32'(err), 32'd1);
    reset = 1'b0;
    #1;
    chk("err clr", 32'(err), 32'd0);
    #3 reset = 1'b1;
    @(posedge clock);
    #1;
    cyc("err lit1", 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    chk("err stays 0", 32'(err), 32'd0);
    idle("err idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
